// File: rtl/peri_bus_pkg.sv
// Shared encodings, widths and types for the peripheral bus request path.
package peri_bus_pkg;

    localparam int unsigned PERI_ADDR_W = 32;
    localparam int unsigned PERI_DATA_W = 32;
    localparam int unsigned PERI_STRB_W = 4;

    // Read data returned when a transaction is force-completed.
    localparam logic [PERI_DATA_W-1:0] PERI_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } peri_state_e;

    typedef struct packed {
        logic [PERI_ADDR_W-1:0] addr;
        logic [PERI_DATA_W-1:0] wdata;
        logic [PERI_STRB_W-1:0] wstrb;
    } peri_req_t;

endpackage

// File: rtl/peri_rr_arb.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
module peri_rr_arb #(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned IDX_W  = $clog2(NUM_PE)
) (
    input  logic [NUM_PE-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_PE-1:0] gnt_oh_c,
    output logic [IDX_W-1:0]  gnt_idx_c,
    output logic              any_c
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_oh_c  = '0;
        gnt_idx_c = '0;
        any_c     = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_PE; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_PE);
            if (!any_c && req[cand]) begin
                any_c           = 1'b1;
                gnt_idx_c       = cand;
                gnt_oh_c[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/peri_req_arbiter.sv
// Merges NUM_PE core requests onto the single peripheral port, one transaction at a time.
// Define PERI_TIMEOUT_EN to force-complete transactions left unanswered for TIMEOUT_CYCLES.
module peri_req_arbiter
    import peri_bus_pkg::*;
#(
    parameter int unsigned NUM_PE         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_PE-1:0]             i_pe_rden,
    input  logic [NUM_PE-1:0]             i_pe_wren,
    input  logic [NUM_PE*PERI_ADDR_W-1:0] i_pe_addr,
    input  logic [NUM_PE*PERI_DATA_W-1:0] i_pe_wdata,
    input  logic [NUM_PE*PERI_STRB_W-1:0] i_pe_wstrb,
    output logic [NUM_PE-1:0]             o_pe_gnt,
    output logic [NUM_PE-1:0]             o_pe_ready,
    output logic [PERI_DATA_W-1:0]        o_pe_rdata,
    output logic                          o_peri_rden,
    output logic                          o_peri_wren,
    output logic [PERI_ADDR_W-1:0]        o_peri_addr,
    output logic [PERI_DATA_W-1:0]        o_peri_wdata,
    output logic [PERI_STRB_W-1:0]        o_peri_wstrb,
    input  logic                          i_peri_ready,
    input  logic [PERI_DATA_W-1:0]        i_peri_rdata,
    output logic                          o_timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_PE);

    if (NUM_PE < 2 || NUM_PE > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
        $error("peri_req_arbiter: unsupported NUM_PE or TIMEOUT_CYCLES");
    end

    peri_state_e       state;
    logic [IDX_W-1:0]  ptr;
    logic [NUM_PE-1:0] owner_oh;

    logic [NUM_PE-1:0] req_c;
    logic [NUM_PE-1:0] gnt_oh_c;
    logic [IDX_W-1:0]  gnt_idx_c;
    logic              any_c;
    peri_req_t         pe_req_c [NUM_PE];
    peri_req_t         win_req_c;
    logic              win_wr_c;
    logic              win_rd_c;

`ifdef PERI_TIMEOUT_EN
    logic [15:0]       to_cnt;
`endif

    assign req_c = i_pe_rden | i_pe_wren;

    for (genvar k = 0; k < NUM_PE; k++) begin : g_unpack
        assign pe_req_c[k] = {i_pe_addr[k*PERI_ADDR_W +: PERI_ADDR_W],
                              i_pe_wdata[k*PERI_DATA_W +: PERI_DATA_W],
                              i_pe_wstrb[k*PERI_STRB_W +: PERI_STRB_W]};
    end

    peri_rr_arb #(
        .NUM_PE (NUM_PE),
        .IDX_W  (IDX_W)
    ) u_rr_arb (
        .req       (req_c),
        .ptr       (ptr),
        .gnt_oh_c  (gnt_oh_c),
        .gnt_idx_c (gnt_idx_c),
        .any_c     (any_c)
    );

    // Write wins when a core raises both strobes.
    assign win_req_c = pe_req_c[gnt_idx_c];
    assign win_wr_c  = i_pe_wren[gnt_idx_c];
    assign win_rd_c  = i_pe_rden[gnt_idx_c] & ~win_wr_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            ptr           <= IDX_W'(NUM_PE - 1);
            owner_oh      <= '0;
            o_pe_gnt      <= '0;
            o_pe_ready    <= '0;
            o_pe_rdata    <= '0;
            o_peri_rden   <= 1'b0;
            o_peri_wren   <= 1'b0;
            o_peri_addr   <= '0;
            o_peri_wdata  <= '0;
            o_peri_wstrb  <= '0;
            o_timeout_err <= 1'b0;
`ifdef PERI_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            o_pe_gnt      <= '0;
            o_peri_rden   <= 1'b0;
            o_peri_wren   <= 1'b0;
            o_timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_c) begin
                        o_pe_gnt     <= gnt_oh_c;
                        o_peri_wren  <= win_wr_c;
                        o_peri_rden  <= win_rd_c;
                        o_peri_addr  <= win_req_c.addr;
                        o_peri_wdata <= win_req_c.wdata;
                        o_peri_wstrb <= win_req_c.wstrb;
                        owner_oh     <= gnt_oh_c;
                        ptr          <= gnt_idx_c;
                        state        <= ST_WAIT;
`ifdef PERI_TIMEOUT_EN
                        to_cnt       <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (i_peri_ready) begin
                        o_pe_ready <= owner_oh;
                        o_pe_rdata <= i_peri_rdata;
                        state      <= ST_RESP;
                    end
`ifdef PERI_TIMEOUT_EN
                    else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        o_pe_ready    <= owner_oh;
                        o_pe_rdata    <= PERI_ERR_RDATA;
                        o_timeout_err <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                ST_RESP: begin
                    o_pe_ready <= '0;
                    o_pe_rdata <= '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peri_req_arbiter.sv
// Randomized scoreboard bench for peri_req_arbiter; a transaction-level model predicts grants and responses.
module tb_peri_req_arbiter;

    localparam int NPE   = 4;
    localparam int TO    = 8;
    localparam int NEVER = 32'h3fff_ffff;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NPE-1:0]    i_pe_rden;
    logic [NPE-1:0]    i_pe_wren;
    logic [NPE*32-1:0] i_pe_addr;
    logic [NPE*32-1:0] i_pe_wdata;
    logic [NPE*4-1:0]  i_pe_wstrb;
    logic [NPE-1:0]    o_pe_gnt;
    logic [NPE-1:0]    o_pe_ready;
    logic [31:0]       o_pe_rdata;
    logic              o_peri_rden;
    logic              o_peri_wren;
    logic [31:0]       o_peri_addr;
    logic [31:0]       o_peri_wdata;
    logic [3:0]        o_peri_wstrb;
    logic              i_peri_ready;
    logic [31:0]       i_peri_rdata;
    logic              o_timeout_err;

    peri_req_arbiter #(.NUM_PE(NPE), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pe_rden     (i_pe_rden),
        .i_pe_wren     (i_pe_wren),
        .i_pe_addr     (i_pe_addr),
        .i_pe_wdata    (i_pe_wdata),
        .i_pe_wstrb    (i_pe_wstrb),
        .o_pe_gnt      (o_pe_gnt),
        .o_pe_ready    (o_pe_ready),
        .o_pe_rdata    (o_pe_rdata),
        .o_peri_rden   (o_peri_rden),
        .o_peri_wren   (o_peri_wren),
        .o_peri_addr   (o_peri_addr),
        .o_peri_wdata  (o_peri_wdata),
        .o_peri_wstrb  (o_peri_wstrb),
        .i_peri_ready  (i_peri_ready),
        .i_peri_rdata  (i_peri_rdata),
        .o_timeout_err (o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { int core; bit wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; int cyc; } gnt_exp_t;
    typedef struct { int core; logic [31:0] rdata; bit err; int cyc; } resp_exp_t;

    gnt_exp_t  gnt_q[$];
    resp_exp_t resp_q[$];

    // Reference model / stimulus state (written only by the stimulus process)
    bit          act [NPE];
    bit          rd  [NPE];
    bit          wr  [NPE];
    logic [31:0] addr [NPE];
    logic [31:0] wdata[NPE];
    logic [3:0]  wstrb[NPE];
    int          last_w, cyc, resp_cyc, cur_w, fix_delay, hang_cnt;
    bit          inflight, cur_resp, rand_en, resp_en, rst_req, stray_pend, use_fix, done;
    logic [31:0] fix_rdata;

    // Scoreboard counters (written only by the monitor)
    int          n_tests = 0;
    int          n_fail  = 0;
    gnt_exp_t    mg;
    resp_exp_t   mr;

    task automatic check(string name, logic [63:0] act_v, logic [63:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    function automatic int pick();
        for (int i = 1; i <= NPE; i++)
            if (act[(last_w + i) % NPE]) return (last_w + i) % NPE;
        return -1;
    endfunction

    function automatic bit any_act();
        for (int k = 0; k < NPE; k++) if (act[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_req(int k, bit r, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        act[k] = 1'b1; rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d; wstrb[k] = s;
    endtask

    task automatic apply();
        for (int k = 0; k < NPE; k++) begin
            i_pe_rden[k]          = act[k] & rd[k];
            i_pe_wren[k]          = act[k] & wr[k];
            i_pe_addr[k*32 +: 32] = addr[k];
            i_pe_wdata[k*32 +: 32] = wdata[k];
            i_pe_wstrb[k*4 +: 4]  = wstrb[k];
        end
    endtask

    // One cycle of stimulus: bus responder, core behaviour, then grant prediction.
    task automatic step();
        int w, d, t;
        logic [31:0] rv;
        @(negedge i_clk);
        cyc++;
        i_rst        = rst_req;
        i_peri_ready = 1'b0;
        if (rst_req) begin
            inflight = 1'b0;
            last_w   = NPE - 1;
            gnt_q.delete();
            resp_q.delete();
            for (int k = 0; k < NPE; k++) act[k] = 1'b0;
        end else if (inflight) begin
            if (cyc == resp_cyc && cur_resp) begin
                rv = use_fix ? fix_rdata : $urandom;
                i_peri_ready = 1'b1;
                i_peri_rdata = rv;
                resp_q.push_back('{cur_w, rv, 1'b0, cyc});
            end
            if (cyc == resp_cyc + 1) act[cur_w] = 1'b0;
            if (cyc >= resp_cyc + 2) inflight = 1'b0;
        end
        if (stray_pend && !inflight && !rst_req) begin
            i_peri_ready = 1'b1;
            i_peri_rdata = $urandom;
            stray_pend   = 1'b0;
        end
        if (rand_en && !rst_req) begin
            for (int k = 0; k < NPE; k++) begin
                if (!act[k] && $urandom_range(0, 2) == 0) begin
                    t = int'($urandom_range(0, 2));
                    set_req(k, t != 1, t != 0, $urandom, $urandom, 4'($urandom));
                end
            end
        end
        apply();
        if (!inflight && !rst_req && any_act()) begin
            w = pick();
            gnt_q.push_back('{w, wr[w], addr[w], wdata[w], wstrb[w], cyc});
            last_w   = w;
            cur_w    = w;
            inflight = 1'b1;
            cur_resp = resp_en;
            if (resp_en) begin
                d = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 5));
                resp_cyc = cyc + 1 + d;
            end else begin
`ifdef PERI_TIMEOUT_EN
                resp_cyc = cyc + TO;
                resp_q.push_back('{w, 32'hDEAD_BEEF, 1'b1, resp_cyc});
`else
                resp_cyc = NEVER;
`endif
            end
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle(int limit);
        int n;
        n = 0;
        while ((inflight || any_act()) && n < limit) begin
            step();
            n++;
        end
        if (inflight || any_act()) hang_cnt++;
    endtask

    // Monitor: compares DUT activity against the queued expectations.
    always @(posedge i_clk) begin
        #1;
        if (i_rst) begin
            check("reset_outputs_zero", 64'(|{o_pe_gnt, o_pe_ready, o_pe_rdata, o_peri_rden, o_peri_wren,
                                              o_peri_addr, o_peri_wdata, o_peri_wstrb, o_timeout_err}), 64'd0);
        end else begin
            if (o_pe_gnt != '0 || o_peri_rden || o_peri_wren) begin
                if (gnt_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_grant: gnt=%b rden=%b wren=%b, required none (cycle %0d)",
                             o_pe_gnt, o_peri_rden, o_peri_wren, cyc);
                end else begin
                    mg = gnt_q.pop_front();
                    check("gnt_vector", 64'(o_pe_gnt), 64'd1 << mg.core);
                    check("gnt_cycle", 64'(cyc), 64'(mg.cyc));
                    check("peri_cmd", 64'({o_peri_rden, o_peri_wren}), mg.wr ? 64'd1 : 64'd2);
                    check("peri_addr", 64'(o_peri_addr), 64'(mg.addr));
                    check("peri_wdata", 64'(o_peri_wdata), 64'(mg.wdata));
                    check("peri_wstrb", 64'(o_peri_wstrb), 64'(mg.wstrb));
                end
            end
            if (o_pe_ready != '0) begin
                if (resp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_ready: ready=%b rdata=%h, required none (cycle %0d)",
                             o_pe_ready, o_pe_rdata, cyc);
                end else begin
                    mr = resp_q.pop_front();
                    check("ready_vector", 64'(o_pe_ready), 64'd1 << mr.core);
                    check("ready_rdata", 64'(o_pe_rdata), 64'(mr.rdata));
                    check("timeout_err", 64'(o_timeout_err), 64'(mr.err));
                    check("ready_cycle", 64'(cyc), 64'(mr.cyc));
                end
            end else if (o_timeout_err) begin
                n_tests++; n_fail++;
                $display("FAIL stray_timeout_err: got 1 without ready, required 0 (cycle %0d)", cyc);
            end
        end
        if (done) begin
            check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
            check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
            check("wait_budget", 64'(hang_cnt), 64'd0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        i_rst = 1'b1; i_peri_ready = 1'b0; i_peri_rdata = '0;
        i_pe_rden = '0; i_pe_wren = '0; i_pe_addr = '0; i_pe_wdata = '0; i_pe_wstrb = '0;
        for (int k = 0; k < NPE; k++) begin
            act[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
        end
        last_w = NPE - 1; cyc = 0; resp_cyc = NEVER; cur_w = 0; fix_delay = -1; hang_cnt = 0;
        inflight = 1'b0; cur_resp = 1'b0; rand_en = 1'b0; resp_en = 1'b1; stray_pend = 1'b0;
        use_fix = 1'b0; done = 1'b0; fix_rdata = '0;
        rst_req = 1'b1;
        run(3);
        rst_req = 1'b0;
        step();

        // Contention after reset: 0,1,3 then re-request from 0
        set_req(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b1, 32'h0000_2000, 32'h1111_2222, 4'hF);
        set_req(3, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
        for (int n = 0; n < 60 && act[0]; n++) step();
        if (act[0]) hang_cnt++;
        set_req(0, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
        wait_idle(120);

        // Single read from core 2 with a fixed bus latency
        use_fix = 1'b1; fix_rdata = 32'h1234_5678; fix_delay = 2;
        set_req(2, 1'b1, 1'b0, 32'h0001_0004, 32'h0, 4'h0);
        wait_idle(50);
        use_fix = 1'b0; fix_delay = -1;

        // Read and write both raised: write wins
        set_req(1, 1'b1, 1'b1, 32'h0000_4000, 32'hA5A5_A5A5, 4'b0011);
        wait_idle(50);

        // Stray bus ready while idle
        stray_pend = 1'b1;
        run(4);

        // Unanswered transaction
        resp_en = 1'b0;
        set_req(3, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
`ifdef PERI_TIMEOUT_EN
        wait_idle(50);
        set_req(2, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'h0);
        run(3);
`else
        run(100);
`endif

        // Reset mid-transaction, stray ready after, pointer back to core 0
        rst_req = 1'b1;
        run(2);
        rst_req = 1'b0;
        resp_en = 1'b1;
        stray_pend = 1'b1;
        run(2);
        set_req(0, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'h0);
        set_req(3, 1'b0, 1'b1, 32'h0000_8000, 32'h5555_AAAA, 4'b1100);
        wait_idle(60);

        // Randomized traffic
        rand_en = 1'b1;
        run(3000);
        rand_en = 1'b0;
        wait_idle(200);
        run(2);
        done = 1'b1;
    end

endmodule
